lsu_ctrl: RTL

- Load/store sequencing controller between the CPU memory stage and the data-memory port.
- Accepts one access at a time and decodes funct3 (LB/LH/LW/LBU/LHU/SB/SH/SW).
- Drives a word-aligned request/grant/rvalid handshake to memory, generates store byte enables and lane-replicated write data, and returns lane-selected, sign- or zero-extended load data.
- Flags misaligned or illegal accesses and memory timeouts without touching memory.

---
 rtl/lsu_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// ============================================================================
// lsu_ctrl : load/store sequencer between the CPU memory stage and the data-memory port
// Rev 1.0
// ============================================================================
`default_nettype none

module lsu_ctrl #(
  parameter int CPU_WORD = 32,
  parameter int ADDR_W   = 32,
  parameter int TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [2:0]          cpu_funct3,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [CPU_WORD-1:0] cpu_wdata,
  output logic                cpu_ready,
  output logic                cpu_done,
  output logic [CPU_WORD-1:0] cpu_rdata,
  output logic                cpu_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [3:0]          mem_be,
  output logic [CPU_WORD-1:0] mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [CPU_WORD-1:0] mem_rdata
);

  localparam int C_CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] C_IDLE = 3'd0;
  localparam logic [2:0] C_REQ  = 3'd1;
  localparam logic [2:0] C_WAIT = 3'd2;
  localparam logic [2:0] C_DONE = 3'd3;
  localparam logic [2:0] C_ERR  = 3'd4;

  logic [2:0]          r_state;
  logic [2:0]          w_next;
  logic                r_we;
  logic [2:0]          r_funct3;
  logic [ADDR_W-1:0]   r_addr;
  logic [CPU_WORD-1:0] r_wdata;
  logic [CPU_WORD-1:0] r_rdata;
  logic [C_CNT_W-1:0]  r_cnt;

  logic                w_illegal;
  logic                w_misalign;
  logic [3:0]          w_be;
  logic [CPU_WORD-1:0] w_wdata;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [CPU_WORD-1:0] w_load_ext;

  // Decode checks act on the live request so errors are known at accept time
  assign w_illegal  = cpu_we ? (cpu_funct3[2] || (cpu_funct3[1:0] == 2'b11))
                             : ((cpu_funct3 == 3'b011) || (cpu_funct3[2:1] == 2'b11));
  assign w_misalign = ((cpu_funct3[1:0] == 2'b01) && cpu_addr[0]) ||
                      ((cpu_funct3[1:0] == 2'b10) && (cpu_addr[1:0] != 2'b00));

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_wdata;
    case (r_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << r_addr[1:0];
        w_wdata = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_byte = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = mem_rdata[{r_addr[1], 4'b0000} +: 16];

  always_comb begin
    w_load_ext = mem_rdata;
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_ext = {24'b0, w_byte};
      3'b101:  w_load_ext = {16'b0, w_half};
      default: w_load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= C_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      C_IDLE: if (cpu_req) w_next = (w_illegal || w_misalign) ? C_ERR : C_REQ;
      C_REQ: begin
        if (mem_gnt)                  w_next = r_we ? C_DONE : C_WAIT;
        else if (r_cnt == C_CNT_LAST) w_next = C_ERR;
      end
      C_WAIT: begin
        if (mem_rvalid)               w_next = C_DONE;
        else if (r_cnt == C_CNT_LAST) w_next = C_ERR;
      end
      C_DONE:  w_next = C_IDLE;
      C_ERR:   w_next = C_IDLE;
      default: w_next = C_IDLE;
    endcase
  end

  always_comb begin
    cpu_ready = 1'b0;
    cpu_done  = 1'b0;
    cpu_err   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = 4'b0000;
    mem_wdata = '0;
    case (r_state)
      C_IDLE: cpu_ready = 1'b1;
      C_REQ: begin
        mem_req   = 1'b1;
        mem_we    = r_we;
        mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
        mem_be    = r_we ? w_be : 4'b0000;
        mem_wdata = r_we ? w_wdata : '0;
      end
      C_DONE:  cpu_done = 1'b1;
      C_ERR:   cpu_err  = 1'b1;
      default: ;
    endcase
  end

  assign cpu_rdata = r_rdata;

  // Counter restarts when entering REQ (from IDLE) and WAIT (on a load grant)
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_cnt    <= '0;
    end else begin
      if (r_state == C_IDLE && cpu_req) begin
        r_we     <= cpu_we;
        r_funct3 <= cpu_funct3;
        r_addr   <= cpu_addr;
        r_wdata  <= cpu_wdata;
      end
      if (r_state == C_IDLE || (r_state == C_REQ && mem_gnt)) r_cnt <= '0;
      else if (r_state == C_REQ || r_state == C_WAIT)         r_cnt <= r_cnt + 1'b1;
      if (r_state == C_WAIT && mem_rvalid) r_rdata <= w_load_ext;
    end
  end

endmodule

`default_nettype wire
